// File: rtl/voice_mixer.sv
// voice_mixer: N-voice volume/mute mixer with master gain, saturation and optional PDM (VOICE_MIXER_PDM_EN)
module voice_mixer #(
  parameter int NUM_VOICES = 3,
  parameter int IN_W       = 10,
  parameter int VOL_W      = 4,
  parameter int OUT_W      = 16,
  parameter int SHIFT      = 3,
  parameter int IDX_W      = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        sample_tick_i,
  input  logic                        voice_valid_i,
  output logic                        voice_ready_o,
  input  logic [IDX_W-1:0]            voice_idx_i,
  input  logic [IN_W-1:0]             voice_data_i,
  input  logic [NUM_VOICES*VOL_W-1:0] voice_vol_i,
  input  logic [NUM_VOICES-1:0]       voice_mute_i,
  input  logic [VOL_W-1:0]            master_vol_i,
  output logic                        audio_valid_o,
  output logic [OUT_W-1:0]            audio_o,
  output logic                        clip_o,
  output logic                        drop_o,
  output logic                        pdm_o
);
  localparam int T_W   = IN_W + VOL_W + 1;
  localparam int ACC_W = T_W + $clog2(NUM_VOICES);
  localparam int P_W   = ACC_W + VOL_W + 1;
  localparam logic signed [P_W-1:0] HI = (2**(OUT_W-1)) - 1;
  localparam logic signed [P_W-1:0] LO = -(2**(OUT_W-1));

  typedef enum logic [1:0] {IDLE, COLLECT, MASTER} state_t;
  state_t state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [NUM_VOICES-1:0] mask_q, mask_d;
  logic [OUT_W-1:0] audio_q, audio_d;
  logic clip_q, clip_d, valid_q, valid_d, drop_q, drop_d;

  logic idx_ok, accept;
  logic [IDX_W-1:0] sel;
  logic [VOL_W-1:0] vol;
  logic signed [IN_W-1:0] s;
  logic signed [T_W-1:0] term;
  logic signed [P_W-1:0] p, r;

  assign idx_ok = int'(voice_idx_i) < NUM_VOICES;
  assign sel    = idx_ok ? voice_idx_i : '0;
  assign accept = voice_valid_i && voice_ready_o && idx_ok && !mask_q[sel];
  assign vol    = voice_vol_i[int'(sel)*VOL_W +: VOL_W];
  // Flipping the MSB converts offset-binary input to two's complement
  assign s      = {~voice_data_i[IN_W-1], voice_data_i[IN_W-2:0]};
  assign term   = voice_mute_i[sel] ? '0 : T_W'(s) * T_W'($signed({1'b0, vol}));
  assign p      = P_W'(acc_q) * P_W'($signed({1'b0, master_vol_i}));
  assign r      = p >>> SHIFT;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mask_d  = mask_q;
    audio_d = audio_q;
    clip_d  = clip_q;
    valid_d = 1'b0;
    drop_d  = 1'b0;
    case (state_q)
      IDLE: if (sample_tick_i) begin
        state_d = COLLECT;
        acc_d   = '0;
        mask_d  = '0;
      end
      COLLECT: if (sample_tick_i) begin
        drop_d = 1'b1;
        acc_d  = '0;
        mask_d = '0;
      end else if (accept) begin
        mask_d  = mask_q | (NUM_VOICES'(1) << sel);
        acc_d   = acc_q + ACC_W'(term);
        state_d = &mask_d ? MASTER : COLLECT;
      end
      MASTER: begin
        audio_d = r > HI ? HI[OUT_W-1:0] : r < LO ? LO[OUT_W-1:0] : r[OUT_W-1:0];
        clip_d  = (r > HI) || (r < LO);
        valid_d = 1'b1;
        acc_d   = '0;
        mask_d  = '0;
        state_d = sample_tick_i ? COLLECT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mask_q  <= '0;
      audio_q <= '0;
      clip_q  <= 1'b0;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mask_q  <= mask_d;
      audio_q <= audio_d;
      clip_q  <= clip_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
    end

  assign voice_ready_o = state_q == COLLECT;
  assign audio_valid_o = valid_q;
  assign audio_o       = audio_q;
  assign clip_o        = clip_q;
  assign drop_o        = drop_q;

`ifdef VOICE_MIXER_PDM_EN
  logic [OUT_W:0] sd_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) sd_q <= '0;
    else sd_q <= {1'b0, sd_q[OUT_W-1:0]} + {1'b0, ~audio_q[OUT_W-1], audio_q[OUT_W-2:0]};
  assign pdm_o = sd_q[OUT_W];
`else
  assign pdm_o = 1'b0;
`endif
endmodule

// File: tb/tb_voice_mixer.sv
// tb_voice_mixer: directed self-checking bench for voice_mixer at default parameters
module tb_voice_mixer;
  logic clk = 0, rst_n = 0, tick = 0, vv = 0;
  logic [1:0] idx = 0;
  logic [9:0] data = 0;
  logic [11:0] vol = 0;
  logic [2:0] mute = 0;
  logic [3:0] mvol = 0;
  logic ready, aval, clip, drop, pdm;
  logic [15:0] audio;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  voice_mixer dut (
    .clk_i(clk), .rst_ni(rst_n), .sample_tick_i(tick), .voice_valid_i(vv),
    .voice_ready_o(ready), .voice_idx_i(idx), .voice_data_i(data),
    .voice_vol_i(vol), .voice_mute_i(mute), .master_vol_i(mvol),
    .audio_valid_o(aval), .audio_o(audio), .clip_o(clip), .drop_o(drop), .pdm_o(pdm)
  );

  // One clock edge with the given inputs; returns on the following negedge
  task automatic cyc(input logic t, input logic v, input logic [1:0] i, input logic [9:0] d);
    tick = t; vv = v; idx = i; data = d;
    @(negedge clk);
    tick = 0; vv = 0;
  endtask

  task automatic frame(input logic [9:0] d0, input logic [9:0] d1, input logic [9:0] d2);
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, d0);
    cyc(0, 1, 1, d1);
    cyc(0, 1, 2, d2);
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_reset;
    rst_n = 0;
    @(negedge clk); @(negedge clk);
    tests++; if ({audio, clip, aval, drop, ready, pdm} !== 21'd0) begin fails++; $display("FAIL reset_outputs: got %h want 0", {audio, clip, aval, drop, ready, pdm}); end
    rst_n = 1;
    cyc(0, 1, 0, 10'h300);
    tests++; if (ready !== 1'b0) begin fails++; $display("FAIL idle_ready: got %b want 0", ready); end
  endtask

  task automatic test_basic;
    vol = {4'd0, 4'd0, 4'd8}; mute = 3'b110; mvol = 15;
    cyc(1, 0, 0, 0);
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL collect_ready: got %b want 1", ready); end
    cyc(0, 1, 0, 10'h300);
    cyc(0, 1, 1, 10'h123);
    cyc(0, 1, 2, 10'h3AB);
    tests++; if (aval !== 1'b0) begin fails++; $display("FAIL latency_early: got %b want 0", aval); end
    cyc(0, 0, 0, 0);
    tests++; if (aval !== 1'b1) begin fails++; $display("FAIL basic_valid: got %b want 1", aval); end
    tests++; if (audio !== 16'd3840 || clip !== 1'b0) begin fails++; $display("FAIL basic_audio: got %0d clip %b want 3840 clip 0", audio, clip); end
    cyc(0, 0, 0, 0);
    tests++; if (aval !== 1'b0) begin fails++; $display("FAIL valid_pulse: got %b want 0", aval); end
  endtask

  task automatic test_saturation;
    vol = 12'hFFF; mute = 0; mvol = 15;
    frame(10'h3FF, 10'h3FF, 10'h3FF);
    tests++; if (audio !== 16'h7FFF || clip !== 1'b1) begin fails++; $display("FAIL sat_pos: got %h clip %b want 7fff clip 1", audio, clip); end
    frame(10'h000, 10'h000, 10'h000);
    tests++; if (audio !== 16'h8000 || clip !== 1'b1) begin fails++; $display("FAIL sat_neg: got %h clip %b want 8000 clip 1", audio, clip); end
  endtask

  task automatic test_ignore;
    vol = 12'hFFF; mute = 0; mvol = 15;
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 10'h3FF);
    cyc(0, 1, 0, 10'h000);
    cyc(0, 1, 3, 10'h000);
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL ignore_ready: got %b want 1", ready); end
    cyc(0, 1, 1, 10'h200);
    cyc(0, 1, 2, 10'h200);
    cyc(0, 0, 0, 0);
    tests++; if (aval !== 1'b1 || audio !== 16'd14371 || clip !== 1'b0) begin fails++; $display("FAIL ignore_audio: got %0d valid %b clip %b want 14371 valid 1 clip 0", audio, aval, clip); end
  endtask

  task automatic test_drop;
    vol = 12'h444; mute = 0; mvol = 15;
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 10'h280);
    cyc(0, 1, 1, 10'h280);
    cyc(1, 0, 0, 0);
    tests++; if (drop !== 1'b1 || audio !== 16'd14371 || ready !== 1'b1) begin fails++; $display("FAIL drop_pulse: got drop %b audio %0d ready %b want 1 14371 1", drop, audio, ready); end
    cyc(0, 1, 2, 10'h280);
    cyc(0, 0, 0, 0);
    tests++; if (aval !== 1'b0 || drop !== 1'b0) begin fails++; $display("FAIL drop_cleared: got valid %b drop %b want 0 0", aval, drop); end
    cyc(0, 1, 0, 10'h280);
    cyc(0, 1, 1, 10'h280);
    cyc(0, 0, 0, 0);
    tests++; if (aval !== 1'b1 || audio !== 16'd2880 || clip !== 1'b0) begin fails++; $display("FAIL drop_refill: got %0d valid %b clip %b want 2880 1 0", audio, aval, clip); end
  endtask

  task automatic test_back_to_back;
    vol = 12'h444; mute = 0; mvol = 15;
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 10'h280);
    cyc(0, 1, 1, 10'h280);
    cyc(0, 1, 2, 10'h280);
    cyc(1, 0, 0, 0);
    tests++; if (aval !== 1'b1 || audio !== 16'd2880 || ready !== 1'b1) begin fails++; $display("FAIL b2b_master_tick: got valid %b audio %0d ready %b want 1 2880 1", aval, audio, ready); end
    vol = 12'hFFF;
    cyc(0, 1, 0, 10'h3FF);
    cyc(0, 1, 1, 10'h3FF);
    cyc(0, 1, 2, 10'h3FF);
    cyc(0, 0, 0, 0);
    tests++; if (aval !== 1'b1 || audio !== 16'h7FFF || clip !== 1'b1) begin fails++; $display("FAIL b2b_second: got %h valid %b clip %b want 7fff 1 1", audio, aval, clip); end
  endtask

  task automatic test_idle_tick_valid;
    vol = {4'd0, 4'd0, 4'd8}; mute = 3'b110; mvol = 15;
    cyc(1, 1, 0, 10'h3FF);
    cyc(0, 1, 0, 10'h300);
    cyc(0, 1, 1, 10'h000);
    cyc(0, 1, 2, 10'h000);
    cyc(0, 0, 0, 0);
    tests++; if (aval !== 1'b1 || audio !== 16'd3840 || clip !== 1'b0) begin fails++; $display("FAIL idle_tick_voice: got %0d valid %b clip %b want 3840 1 0", audio, aval, clip); end
  endtask

  task automatic test_reset_mid;
    logic seen;
    vol = {4'd0, 4'd0, 4'd8}; mute = 3'b110; mvol = 15;
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 10'h300);
    #2 rst_n = 0;
    #1;
    tests++; if ({audio, clip, aval, drop, ready, pdm} !== 21'd0) begin fails++; $display("FAIL reset_async: got %h want 0", {audio, clip, aval, drop, ready, pdm}); end
    @(negedge clk);
    rst_n = 1;
    seen = 0;
    cyc(0, 1, 1, 10'h000); seen |= aval | ready;
    cyc(0, 1, 2, 10'h000); seen |= aval | ready;
    cyc(0, 0, 0, 0);       seen |= aval | ready;
    cyc(0, 0, 0, 0);       seen |= aval | ready;
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL reset_no_valid: got %b want 0", seen); end
    frame(10'h300, 10'h000, 10'h000);
    tests++; if (aval !== 1'b1 || audio !== 16'd3840) begin fails++; $display("FAIL reset_refill: got %0d valid %b want 3840 1", audio, aval); end
  endtask

  task automatic test_pdm;
    int cnt;
    vol = {4'd8, 4'd15, 4'd15}; mute = 0; mvol = 8;
    frame(10'h3F4, 10'h3F4, 10'h2AD);
    tests++; if (audio !== 16'h4000 || clip !== 1'b0) begin fails++; $display("FAIL pdm_level: got %h clip %b want 4000 0", audio, clip); end
    cnt = 0;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      cnt += int'(pdm);
    end
`ifdef VOICE_MIXER_PDM_EN
    tests++; if (cnt < 767 || cnt > 769) begin fails++; $display("FAIL pdm_duty: got %0d want 768+/-1", cnt); end
`else
    tests++; if (cnt != 0) begin fails++; $display("FAIL pdm_off: got %0d want 0", cnt); end
`endif
  endtask

  initial begin
    test_reset;
    test_basic;
    test_saturation;
    test_ignore;
    test_drop;
    test_back_to_back;
    test_idle_tick_valid;
    test_reset_mid;
    test_pdm;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
